// File: rtl/rbm_hidden_sampler.sv
// Stochastic RBM hidden-unit evaluator: bias plus masked weights into a saturating
// Q8.8 accumulator, then a piecewise-linear sigmoid and a Bernoulli draw against an LFSR.

// Piecewise-linear sigmoid of a signed Q8.8 value; 8-bit probability, all-ones ~ 1.0.
module rbm_sigmoid #(
    parameter int unsigned IW = 16,
    parameter int unsigned OW = 8
) (
    input  logic signed [IW-1:0] x,
    output logic        [OW-1:0] y
);
    localparam int unsigned LW   = IW + 1;
    localparam int unsigned MAXV = (1 << OW) - 1;
    localparam logic [IW-1:0] ONE = IW'(256);
    localparam logic [IW-1:0] BP2 = IW'(608);
    localparam logic [IW-1:0] BP3 = IW'(1280);

    logic [IW-1:0] mag;
    logic [LW-1:0] lin;
    logic [OW-1:0] pos;

    // Evaluate on |x|, then mirror negative inputs around 1.0
    always_comb begin
        mag = x[IW-1] ? IW'(~x + IW'(1)) : IW'(x);
        lin = LW'(MAXV);
        if (mag <= ONE) begin
            lin = LW'(mag >> 2) + LW'(128);
        end else if (mag <= BP2) begin
            lin = LW'(mag >> 3) + LW'(160);
        end else if (mag <= BP3) begin
            lin = LW'(mag >> 5) + LW'(216);
        end
        pos = (lin > LW'(MAXV)) ? '1 : lin[OW-1:0];
        y   = x[IW-1] ? ~pos : pos;
    end
endmodule

module rbm_hidden_sampler #(
    parameter int unsigned NUM_VIS           = 8,
    parameter int unsigned input_bitlength   = 16,
    parameter int unsigned sigmoid_bitlength = 8,
    parameter logic [7:0]  LFSR_SEED         = 8'hA5
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic signed [input_bitlength-1:0]  bias,
    input  logic        [NUM_VIS-1:0]          vis_bits,
    output logic        [$clog2(NUM_VIS)-1:0]  w_addr,
    input  logic signed [input_bitlength-1:0]  w_data,
    output logic                               busy,
    output logic                               done,
    output logic        [sigmoid_bitlength-1:0] prob,
    output logic                               sample
);
    localparam int unsigned IW    = input_bitlength;
    localparam int unsigned OW    = sigmoid_bitlength;
    localparam int unsigned IDX_W = $clog2(NUM_VIS);
    localparam logic [IW-1:0] POS_MAX = {1'b0, {(IW-1){1'b1}}};
    localparam logic [IW-1:0] NEG_MIN = {1'b1, {(IW-2){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, ACCUM, ACT} state_t;

    state_t                state;
    logic signed [IW-1:0]  acc;
    logic [IDX_W-1:0]      idx;
    logic [NUM_VIS-1:0]    vis_reg;
    logic [7:0]            lfsr;
    logic [OW-1:0]         s;

    // Guard-bit add; the most negative code is excluded so the sigmoid negate never overflows
    function automatic logic signed [IW-1:0] sat_add(input logic signed [IW-1:0] a,
                                                     input logic signed [IW-1:0] b);
        logic [IW:0] sum;
        sum = {a[IW-1], a} + {b[IW-1], b};
        if (!sum[IW] && sum[IW-1]) begin
            return POS_MAX;
        end else if (sum[IW] && (!sum[IW-1] || sum[IW-2:0] == '0)) begin
            return NEG_MIN;
        end
        return sum[IW-1:0];
    endfunction

    rbm_sigmoid #(.IW(IW), .OW(OW)) u_sigmoid (
        .x (acc),
        .y (s)
    );

    assign w_addr = idx;

    // Evaluation sequencer: capture, accumulate one weight per cycle, activate and sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            acc     <= '0;
            idx     <= '0;
            vis_reg <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            prob    <= '0;
            sample  <= 1'b0;
            lfsr    <= LFSR_SEED;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        acc     <= sat_add(bias, '0);
                        idx     <= '0;
                        vis_reg <= vis_bits;
                        busy    <= 1'b1;
                        state   <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (vis_reg[idx]) begin
                        acc <= sat_add(acc, w_data);
                    end
                    if (idx == IDX_W'(NUM_VIS - 1)) begin
                        state <= ACT;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                ACT: begin
                    prob   <= s;
                    sample <= (s > lfsr);
                    lfsr   <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/rbm_hidden_sampler.md
Name: rbm_hidden_sampler

Overview:
- Sequences one stochastic RBM hidden-unit evaluation.
- Accumulates bias plus the weights selected by active visible bits into a Q8.8 signed sum, passes the sum through an internal sigmoid instance, then Bernoulli-samples the result against an 8-bit LFSR.
- Sits between the weight memory and the hidden-state register file; one evaluation per start.

Parameters:
- NUM_VIS, 8: visible units per evaluation (2..256).
- input_bitlength, 16: accumulator/weight width, signed Q8.8.
- sigmoid_bitlength, 8: probability width, unsigned, 0xFF≈1.0.
- LFSR_SEED, 8'hA5: LFSR reset value; must be nonzero.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request an evaluation; sampled only in IDLE.
- bias  in  input_bitlength  signed Q8.8 bias; captured with start.
- vis_bits  in  NUM_VIS  visible states; captured with start.
- w_addr  out  $clog2(NUM_VIS)  weight index to memory; equals idx.
- w_data  in  input_bitlength  signed weight; combinational read, valid in the same cycle as w_addr.
- busy  out  1  evaluation in progress.
- done  out  1  one-cycle pulse; prob/sample valid.
- prob  out  sigmoid_bitlength  sigmoid(sum).
- sample  out  1  Bernoulli sample.

Behaviour:
- Reset (async on rst_n low):
  - state=IDLE, acc=0, idx=0, vis_reg=0, busy=0, done=0, prob=0, sample=0, lfsr=LFSR_SEED.
  - Reset mid-evaluation aborts it; no done pulse is produced.
- FSM states: IDLE, ACCUM, ACT.
- IDLE:
  - On start=1: acc<=bias, idx<=0, vis_reg<=vis_bits, busy<=1, state<=ACCUM.
  - start in any other state is ignored. vis_bits/bias changes after capture have no effect.
- ACCUM, one index per cycle:
  - If vis_reg[idx]: acc<=sat_add(acc,w_data).
  - If idx==NUM_VIS-1: state<=ACT. Otherwise idx<=idx+1.
  - Takes exactly NUM_VIS cycles.
- sat_add: signed two's-complement add.
  - Positive overflow clamps to 0x7FFF.
  - Negative overflow clamps to 0x8001. acc never holds 0x8000, so the sigmoid's internal negate is always representable.
- Sigmoid: an internal sigmoid instance is driven combinationally from acc. Its piecewise-linear approximation on |x| in Q8.8 is:
  - |x| ≤ 1.0: 0.25|x|+0.5
  - 1.0 < |x| ≤ 2.375: 0.125|x|+0.625
  - 2.375 < |x| ≤ 5: 0.03125|x|+0.84375
  - |x| > 5: 1.0 (0xFF)
  - Negative x gives 0xFF minus the positive result.
  - Output saturates to 0xFF on overflow.
- ACT, single cycle:
  - prob<=s.
  - sample<=(s > lfsr), unsigned compare against the pre-advance lfsr.
  - LFSR advances once.
  - done<=1, busy<=0, state<=IDLE.
- done is high for exactly one cycle; clears the following cycle.
- prob/sample hold until the next ACT.
- Latency: start sampled at edge E0 → done high after edge E(NUM_VIS+1), i.e. NUM_VIS+1 cycles. busy is high from E0 to E(NUM_VIS+1).
- Back-to-back: a start asserted in the done cycle is accepted (state is IDLE), giving a throughput of NUM_VIS+2 cycles per evaluation.
- LFSR: 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1.
  - Next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
  - Advances only in ACT. Sequence from 0xA5: 0xA5, 0x4A, ...
- Arithmetic widths:
  - acc uses input_bitlength bits plus one internal guard bit for overflow detection.
  - idx uses $clog2(NUM_VIS) bits; no wrap occurs because ACCUM exits at NUM_VIS-1.

Test Plan:
1. Reset mid-evaluation: assert rst_n=0 during ACCUM at idx=3 → busy=0, done never pulses, prob=0, lfsr=0xA5. A fresh start after release runs normally.
2. Zero sum: bias=0, vis_bits=0 → done after NUM_VIS+1 cycles, prob=0x80, sample=0 (128 ≤ 0xA5). w_addr steps 0..7 on consecutive cycles.
3. Bias 1.0 twice back-to-back: bias=0x0100, vis_bits=0, start re-asserted in the done cycle → both runs give prob=192 (0xC0). First sample=1 (vs 0xA5), second sample=1 (vs 0x4A). Second done comes exactly NUM_VIS+2 cycles after the first.
4. Masking: vis_bits=8'b0000_0101, w[i]=0x0040*(i+1), bias=0 → acc=0x0100, prob=0xC0. Toggling vis_bits during ACCUM has no effect.
5. Negative input: bias=0xFF00 (-1.0), vis_bits=0 → prob=63 (0xFF-0xC0).
6. Saturation, positive: all vis=1, all w=0x7000 → acc=0x7FFF, prob=0xFF, sample=1.
7. Saturation, negative: all vis=1, all w=0x9000 → acc=0x8001, prob=0x00, sample=0.
8. Busy guard: pulse start during ACCUM → ignored; only one done pulse is produced.
